// File: rtl/uart_rx_framer.sv
// uart_rx_framer: assembles SYNC, LEN, payload[LEN], CHK frames from a UART byte strobe
// and holds one validated payload on a fall-through read port. Optional macro: FRAMER_TIMEOUT_EN.
module uart_rx_framer #(
   parameter logic [7:0] SYNC_BYTE      = 8'hA5,
   parameter int         MAX_LEN        = 16,
   parameter int         LEN_BITS       = 5,
   parameter int         TIMEOUT_CYCLES = 4340,
   parameter int         TO_BITS        = 16
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                rx_valid,
   input  logic [7:0]          rx_data,
   output logic                frm_ready,
   output logic [LEN_BITS-1:0] frm_len,
   input  logic                rd_en,
   output logic [7:0]          rd_data,
   output logic                rd_last,
   output logic                busy,
   output logic                err_chk,
   output logic                err_len,
   output logic                err_timeout,
   output logic                overrun,
   output logic [2:0]          dbg_state
);

   // rx_valid is a one-cycle strobe with no backpressure; rd_en pops rd_data only while frm_ready=1.
   typedef enum logic [2:0] {
      S_HUNT    = 3'd0,
      S_LEN     = 3'd1,
      S_PAYLOAD = 3'd2,
      S_CHECK   = 3'd3,
      S_HOLD    = 3'd4
   } state_t;

   localparam int                  AW        = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
   localparam int                  DEPTH     = 1 << AW;
   localparam logic [7:0]          MAX_LEN_B = 8'(MAX_LEN);
   localparam logic [LEN_BITS-1:0] LEN_ONE   = LEN_BITS'(1);

   state_t              state_q, state_d;
   logic [LEN_BITS-1:0] len_q, len_d;
   logic [LEN_BITS-1:0] wptr_q, wptr_d;
   logic [LEN_BITS-1:0] rptr_q, rptr_d;
   logic [7:0]          acc_q, acc_d;
   logic                err_chk_q, err_chk_d;
   logic                err_len_q, err_len_d;
   logic                overrun_q, overrun_d;
   logic [7:0]          buf_q [DEPTH];
   logic                buf_we;
   logic                busy_w;
   logic                hold_last;
   logic                timeout_hit;

   assign busy_w    = (state_q == S_LEN) || (state_q == S_PAYLOAD) || (state_q == S_CHECK);
   assign hold_last = (rptr_q == len_q - LEN_ONE);

   always_comb begin
      state_d   = state_q;
      len_d     = len_q;
      wptr_d    = wptr_q;
      rptr_d    = rptr_q;
      acc_d     = acc_q;
      err_chk_d = 1'b0;
      err_len_d = 1'b0;
      overrun_d = 1'b0;
      buf_we    = 1'b0;
      case (state_q)
         S_HUNT: begin
            if (rx_valid && (rx_data == SYNC_BYTE)) state_d = S_LEN;
         end
         S_LEN: begin
            if (rx_valid) begin
               if ((rx_data == 8'd0) || (rx_data > MAX_LEN_B)) begin
                  err_len_d = 1'b1;
                  state_d   = S_HUNT;
               end else begin
                  len_d   = rx_data[LEN_BITS-1:0];
                  wptr_d  = '0;
                  acc_d   = rx_data;
                  state_d = S_PAYLOAD;
               end
            end
         end
         S_PAYLOAD: begin
            if (rx_valid) begin
               buf_we = 1'b1;
               wptr_d = wptr_q + LEN_ONE;
               acc_d  = acc_q ^ rx_data;
               if (wptr_q == len_q - LEN_ONE) state_d = S_CHECK;
            end
         end
         S_CHECK: begin
            if (rx_valid) begin
               if (rx_data == acc_q) begin
                  state_d = S_HOLD;
                  rptr_d  = '0;
               end else begin
                  err_chk_d = 1'b1;
                  state_d   = S_HUNT;
               end
            end
         end
         S_HOLD: begin
            // A byte arriving here is lost, even in the cycle the last pop releases the frame.
            overrun_d = rx_valid;
            if (rd_en) begin
               if (hold_last) begin
                  state_d = S_HUNT;
                  rptr_d  = '0;
               end else begin
                  rptr_d = rptr_q + LEN_ONE;
               end
            end
         end
         default: state_d = S_HUNT;
      endcase
      if (timeout_hit) state_d = S_HUNT;
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q   <= S_HUNT;
         len_q     <= '0;
         wptr_q    <= '0;
         rptr_q    <= '0;
         acc_q     <= '0;
         err_chk_q <= 1'b0;
         err_len_q <= 1'b0;
         overrun_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         len_q     <= len_d;
         wptr_q    <= wptr_d;
         rptr_q    <= rptr_d;
         acc_q     <= acc_d;
         err_chk_q <= err_chk_d;
         err_len_q <= err_len_d;
         overrun_q <= overrun_d;
      end
   end

   always_ff @(posedge clock) begin
      if (buf_we) buf_q[wptr_q[AW-1:0]] <= rx_data;
   end

`ifdef FRAMER_TIMEOUT_EN
   logic [TO_BITS-1:0] to_cnt_q, to_cnt_d;
   logic               err_timeout_q;

   // A strobe in the terminal-count cycle wins and restarts the idle count.
   always_comb begin
      to_cnt_d    = '0;
      timeout_hit = 1'b0;
      if (busy_w && !rx_valid) begin
         if (to_cnt_q == TO_BITS'(TIMEOUT_CYCLES - 1)) timeout_hit = 1'b1;
         else to_cnt_d = to_cnt_q + TO_BITS'(1);
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         to_cnt_q      <= '0;
         err_timeout_q <= 1'b0;
      end else begin
         to_cnt_q      <= to_cnt_d;
         err_timeout_q <= timeout_hit;
      end
   end

   assign err_timeout = err_timeout_q;
`else
   logic unused_timeout_cfg;
   assign unused_timeout_cfg = ^{32'(TIMEOUT_CYCLES), 32'(TO_BITS)};
   assign timeout_hit        = 1'b0;
   assign err_timeout        = 1'b0;
`endif

   assign frm_ready = (state_q == S_HOLD);
   assign frm_len   = frm_ready ? len_q : '0;
   assign rd_data   = frm_ready ? buf_q[rptr_q[AW-1:0]] : 8'h00;
   assign rd_last   = frm_ready && hold_last;
   assign busy      = busy_w;
   assign err_chk   = err_chk_q;
   assign err_len   = err_len_q;
   assign overrun   = overrun_q;
   assign dbg_state = state_q;

endmodule

// File: tb/tb_uart_rx_framer.sv
// Bench for uart_rx_framer: directed and random byte streams are parsed by a stream-level
// model into expected payload bytes and error events, checked by an independent monitor.
`timescale 1ns/1ps
module tb_uart_rx_framer;

   localparam int         LEN_BITS = 5;
   localparam int         MAX_LEN  = 16;
   localparam logic [7:0] SYNC     = 8'hA5;
   localparam int         W        = LEN_BITS + 1 + 8;
   localparam int         EV_CHK   = 1;
   localparam int         EV_LEN   = 2;
   localparam int         EV_TO    = 3;
   localparam int         EV_OVR   = 4;

   logic                clock = 1'b0;
   logic                reset = 1'b0;
   logic                rx_valid = 1'b0;
   logic [7:0]          rx_data = 8'h00;
   logic                rd_en = 1'b0;
   logic                frm_ready;
   logic [LEN_BITS-1:0] frm_len;
   logic [7:0]          rd_data;
   logic                rd_last;
   logic                busy;
   logic                err_chk;
   logic                err_len;
   logic                err_timeout;
   logic                overrun;
   logic [2:0]          dbg_state;

   logic [W-1:0] exp_q[$];
   int           ev_q[$];
   int           n_checks = 0;
   int           n_pass = 0;
   bit           rd_allow = 1'b0;
   bit           rd_force = 1'b0;

   uart_rx_framer #(
      .SYNC_BYTE(8'hA5), .MAX_LEN(MAX_LEN), .LEN_BITS(LEN_BITS),
      .TIMEOUT_CYCLES(50), .TO_BITS(16)
   ) dut (
      .clock(clock), .reset(reset), .rx_valid(rx_valid), .rx_data(rx_data),
      .frm_ready(frm_ready), .frm_len(frm_len), .rd_en(rd_en), .rd_data(rd_data),
      .rd_last(rd_last), .busy(busy), .err_chk(err_chk), .err_len(err_len),
      .err_timeout(err_timeout), .overrun(overrun), .dbg_state(dbg_state)
   );

   // clock / watchdog
   always #5 clock = ~clock;

   initial begin
      #600000;
      $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_checks);
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
   endtask

   // Reference model: walks a complete byte stream, starting with the parser hunting.
   function automatic void model_stream(input logic [7:0] s[$]);
      int         i;
      int         n;
      int         len;
      logic [7:0] x;
      logic [W-1:0] e;
      i = 0;
      n = s.size();
      while (i < n) begin
         if (s[i] != SYNC) begin
            i++;
            continue;
         end
         if (i + 1 >= n) return;
         len = int'(s[i+1]);
         if (len == 0 || len > MAX_LEN) begin
            ev_q.push_back(EV_LEN);
            i += 2;
            continue;
         end
         if (i + 2 + len >= n) return;
         x = 8'h00;
         for (int k = 1; k <= len + 1; k++) x = x ^ s[i+k];
         if (s[i+2+len] == x) begin
            for (int k = 0; k < len; k++) begin
               e = {LEN_BITS'(len), (k == len - 1), s[i+2+k]};
               exp_q.push_back(e);
            end
         end else begin
            ev_q.push_back(EV_CHK);
         end
         i += 3 + len;
      end
   endfunction

   // driver tasks: inputs change 1ns after the rising edge
   task automatic send_byte(input logic [7:0] b, input int gap);
      rx_data  = b;
      rx_valid = 1'b1;
      @(posedge clock); #1;
      rx_valid = 1'b0;
      rx_data  = 8'($urandom_range(0, 255));
      repeat (gap) begin
         @(posedge clock); #1;
      end
   endtask

   task automatic send_stream(input logic [7:0] s[$], input int max_gap);
      model_stream(s);
      foreach (s[k]) send_byte(s[k], (k == s.size() - 1) ? 0 : $urandom_range(0, max_gap));
   endtask

   task automatic wait_drain();
      int cyc;
      cyc = 0;
      while ((frm_ready || exp_q.size() != 0 || ev_q.size() != 0) && cyc < 3000) begin
         @(posedge clock); #1;
         cyc++;
      end
      check("drain_within_budget", 32'(cyc < 3000), 32'd1);
      if (cyc >= 3000) begin
         exp_q.delete();
         ev_q.delete();
      end
      repeat (2) begin
         @(posedge clock); #1;
      end
   endtask

   // reader: random pops, or a forced pop for the coincident-byte case
   initial begin
      forever begin
         @(posedge clock); #2;
         rd_en = rd_force || (rd_allow && ($urandom_range(0, 2) == 0));
      end
   end

   task automatic take_event(input int code, input string name);
      int e;
      if (ev_q.size() == 0) begin
         n_checks++;
         $display("FAIL %s: pulse seen (code %0d), expected no error event", name, code);
      end else begin
         e = ev_q.pop_front();
         check(name, 32'(code), 32'(e));
      end
   endtask

   // scoreboard monitor: samples on the falling edge
   initial begin
      bit           expect_drop;
      logic [W-1:0] e;
      expect_drop = 1'b0;
      forever begin
         @(negedge clock);
         if (!reset) begin
            expect_drop = 1'b0;
            continue;
         end
         if (expect_drop) begin
            check("ready_low_after_last_pop", 32'(frm_ready), 32'd0);
            expect_drop = 1'b0;
         end
         if (frm_ready && rd_en) begin
            if (exp_q.size() == 0) begin
               n_checks++;
               $display("FAIL frame_byte: popped %0h, expected no frame", {frm_len, rd_last, rd_data});
            end else begin
               e = exp_q.pop_front();
               check("frame_byte", 32'({frm_len, rd_last, rd_data}), 32'(e));
               expect_drop = e[8];
            end
         end
         if (err_chk)     take_event(EV_CHK, "err_chk_event");
         if (err_len)     take_event(EV_LEN, "err_len_event");
         if (err_timeout) take_event(EV_TO, "err_timeout_event");
         if (overrun)     take_event(EV_OVR, "overrun_event");
      end
   end

   initial begin
      logic [7:0] s[$];
      logic [7:0] x;
      int         kind;
      int         len;

      // reset block
      reset = 1'b0;
      repeat (3) @(posedge clock);
      #1;
      check("reset_outputs", 32'({frm_ready, frm_len, rd_data, rd_last, busy, err_chk,
                                  err_len, err_timeout, overrun, dbg_state}), 32'd0);
      reset = 1'b1;
      @(posedge clock); #1;
      rd_allow = 1'b1;

      // good frame
      s = '{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h03};
      send_stream(s, 0);
      check("good_ready_latency", 32'(frm_ready), 32'd1);
      check("good_frm_len", 32'(frm_len), 32'd3);
      wait_drain();

      // bad checksum, then a one-byte frame
      s = '{8'hA5, 8'h02, 8'h10, 8'h20, 8'h31};
      send_stream(s, 0);
      check("bad_chk_pulse", 32'(err_chk), 32'd1);
      check("bad_chk_no_ready", 32'(frm_ready), 32'd0);
      wait_drain();
      s = '{8'hA5, 8'h01, 8'h7E, 8'h7F};
      send_stream(s, 0);
      wait_drain();

      // length errors and a stray byte in HUNT
      s = '{8'hA5, 8'h00};
      send_stream(s, 0);
      check("len_zero_pulse", 32'(err_len), 32'd1);
      check("len_zero_not_busy", 32'(busy), 32'd0);
      wait_drain();
      s = '{8'hA5, 8'h11, 8'h12};
      send_stream(s, 0);
      check("len_17_idle", 32'({busy, dbg_state}), 32'd0);
      wait_drain();

      // noise and embedded sync bytes
      s = '{8'h00, 8'hFF, 8'hA5, 8'h02, 8'hA5, 8'hA5, 8'h02};
      send_stream(s, 1);
      check("embedded_sync_ready", 32'(frm_ready), 32'd1);
      wait_drain();

      // overrun while holding
      rd_allow = 1'b0;
      s = '{8'hA5, 8'h02, 8'hC3, 8'h3C, 8'hFD};
      send_stream(s, 0);
      for (int k = 0; k < 3; k++) begin
         ev_q.push_back(EV_OVR);
         send_byte(8'($urandom_range(0, 255)), 1);
      end
      check("overrun_held_frame", 32'({frm_ready, frm_len, rd_data}), 32'({1'b1, 5'd2, 8'hC3}));
      rd_allow = 1'b1;
      wait_drain();

      // byte coincident with the final pop
      rd_allow = 1'b0;
      s = '{8'hA5, 8'h01, 8'h5A, 8'h5B};
      send_stream(s, 0);
      @(posedge clock); #1;
      ev_q.push_back(EV_OVR);
      rd_force = 1'b1;
      send_byte(8'hA5, 0);
      rd_force = 1'b0;
      check("coincident_pop_hunt", 32'({frm_ready, busy, dbg_state}), 32'd0);
      rd_allow = 1'b1;
      s = '{8'hA5, 8'h01, 8'h66, 8'h67};
      send_stream(s, 0);
      wait_drain();

`ifdef FRAMER_TIMEOUT_EN
      ev_q.push_back(EV_TO);
      send_byte(8'hA5, 0);
      send_byte(8'h04, 0);
      send_byte(8'h01, 50);
      check("timeout_pulse", 32'({err_timeout, busy}), 32'({1'b1, 1'b0}));
      wait_drain();
      s = '{8'hA5, 8'h03, 8'h01, 8'h02, 8'h03, 8'h01};
      send_stream(s, 0);
      wait_drain();
      s = '{8'hA5, 8'h03, 8'h01, 8'h02, 8'h03, 8'h01};
      model_stream(s);
      foreach (s[k]) send_byte(s[k], (k == s.size() - 1) ? 0 : 49);
      check("gap_49_accepted", 32'(frm_ready), 32'd1);
      wait_drain();
`else
      s = '{8'hA5, 8'h04, 8'h01, 8'h02, 8'h03, 8'h04, 8'h00};
      model_stream(s);
      send_byte(8'hA5, 0);
      send_byte(8'h04, 0);
      send_byte(8'h01, 60);
      check("long_idle_still_busy", 32'(busy), 32'd1);
      send_byte(8'h02, 0);
      send_byte(8'h03, 0);
      send_byte(8'h04, 0);
      send_byte(8'h00, 0);
      check("long_idle_accepted", 32'(frm_ready), 32'd1);
      wait_drain();
`endif

      // reset mid-payload
      send_byte(8'hA5, 0);
      send_byte(8'h04, 0);
      send_byte(8'h01, 0);
      send_byte(8'h02, 0);
      check("busy_before_reset", 32'(busy), 32'd1);
      reset = 1'b0;
      #1;
      check("reset_mid_frame_outputs", 32'({frm_ready, frm_len, rd_data, rd_last, busy, err_chk,
                                            err_len, err_timeout, overrun, dbg_state}), 32'd0);
      @(posedge clock); #1;
      reset = 1'b1;
      @(posedge clock); #1;
      s = '{8'hA5, 8'h02, 8'h10, 8'h20, 8'h32};
      send_stream(s, 0);
      wait_drain();

      // random bursts: noise, then one frame attempt
      for (int b = 0; b < 40; b++) begin
         s.delete();
         for (int k = 0; k < $urandom_range(0, 2); k++) begin
            x = 8'($urandom_range(0, 255));
            if (x == SYNC) x = 8'h00;
            s.push_back(x);
         end
         s.push_back(SYNC);
         kind = $urandom_range(0, 3);
         if (kind == 0) begin
            len = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(MAX_LEN + 1, 255);
            s.push_back(8'(len));
         end else begin
            case ($urandom_range(0, 3))
               0:       len = 1;
               1:       len = MAX_LEN;
               default: len = $urandom_range(1, MAX_LEN);
            endcase
            s.push_back(8'(len));
            x = 8'(len);
            for (int k = 0; k < len; k++) begin
               s.push_back(($urandom_range(0, 5) == 0) ? SYNC : 8'($urandom_range(0, 255)));
               x = x ^ s[s.size()-1];
            end
            if (kind == 1) x = x ^ 8'($urandom_range(1, 255));
            s.push_back(x);
         end
         send_stream(s, 3);
         wait_drain();
      end

      check("exp_q_empty", 32'(exp_q.size()), 32'd0);
      check("ev_q_empty", 32'(ev_q.size()), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
